pt_sort_sched: RTL
==================

Name: pt_sort_sched

Overview:
- Job scheduler for the point RAM and the bitonic sorter.
- Sequences each sort job through four phases:
  - LOAD: streams input points into the point RAM.
  - SORT: hands both RAM ports to the sorter and waits for its done pulse.
  - DRAIN: streams the sorted points out under backpressure.
  - Returns to IDLE.
- Sits between the host stream interfaces and the point RAM/sorter pair. It is the single owner of the RAM port mux.

Parameters:
- ADDR_BITS, 10, point RAM address width; maximum job length is 2^ADDR_BITS.
- DATA_WIDTH, 32, point word width.
- TIMEOUT_CYC, 65535, maximum SORT-phase cycles before abort; used only with PT_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  job request pulse; sampled only in IDLE
- log2_len  in  4  job length exponent; N = 1<<log2_len
- busy  out  1  high in any phase other than IDLE
- err  out  1  one-cycle error pulse
- in_valid / in_ready / in_data  in / out / DATA_WIDTH  load stream
- out_valid / out_ready / out_data / out_last  out / in / DATA_WIDTH / 1  drain stream
- sort_start  out  1  one-cycle pulse to the sorter
- sort_log2_len  out  4  registered log2_len for the sorter
- sort_done  in  1  sorter completion pulse
- s_addra, s_addrb  in  ADDR_BITS  sorter RAM addresses
- s_dia  in  DATA_WIDTH  sorter write data
- s_we  in  1  sorter write enable
- ram_addra, ram_addrb  out  ADDR_BITS  to point RAM
- ram_dia  out  DATA_WIDTH  to point RAM
- ram_we  out  1  to point RAM
- ram_dob  in  DATA_WIDTH  from point RAM; 1-cycle read latency
- phase  out  2  0 = IDLE, 1 = LOAD, 2 = SORT, 3 = DRAIN

Behaviour:
- Reset values (rst high at a clock edge):
  - State goes to IDLE; all counters and the drain buffer clear.
  - busy, err, in_ready, out_valid, out_last, sort_start, ram_we are 0.
  - ram_addra, ram_addrb, ram_dia, out_data, sort_log2_len are 0.
  - rst mid-job aborts the job immediately. No sort_start or further writes follow.
- IDLE:
  - start=1 with log2_len <= ADDR_BITS: latch log2_len, clear wr_cnt, go to LOAD next cycle.
  - start=1 with log2_len > ADDR_BITS: pulse err for one cycle and remain in IDLE.
  - start is ignored in every other phase.
- LOAD:
  - in_ready=1 throughout the phase.
  - Each in_valid&in_ready beat writes the same cycle: ram_we=1, ram_addra=wr_cnt, ram_dia=in_data; then wr_cnt increments.
  - After beat N-1, go to SORT. in_ready is 0 the following cycle.
- SORT:
  - sort_start pulses in the first SORT cycle.
  - The RAM mux passes s_addra, s_addrb, s_dia, s_we straight through (combinational), in SORT only.
  - Outside SORT, the sorter inputs are ignored and ram_we is driven by the scheduler only.
  - sort_done=1 goes to DRAIN next cycle. sort_done outside SORT is ignored.
- DRAIN:
  - Reads addresses 0..N-1 ascending on port B; data returns on ram_dob one cycle after the address.
  - A 2-entry output buffer holds returned data.
  - A read issues only when buffer occupancy plus in-flight reads is less than 2, so no data is lost under out_ready=0.
  - out_valid = buffer non-empty; out_data = buffer head.
  - out_last=1 on the beat carrying address N-1.
  - The transfer of the last beat returns to IDLE next cycle; busy drops that cycle.
  - Throughput is 1 beat/cycle with out_ready held high. First out_valid appears 2 cycles after entering DRAIN.
- N=1 (log2_len=0): one load beat; the sort still runs; one drain beat with out_last=1.
- Counters are ADDR_BITS+1 wide so that N = 2^ADDR_BITS terminates without wrap.

Optional Feature:
- PT_SCHED_TIMEOUT_EN defined:
  - A SORT-phase cycle counter runs.
  - If it reaches TIMEOUT_CYC without sort_done: pulse err, go to IDLE, skip DRAIN.
- Not defined: no counter; SORT waits indefinitely; err comes only from the bad-length check.

Decomposition:
- Shared package/defines: phase encodings (PH_IDLE, PH_LOAD, PH_SORT, PH_DRAIN), PT_RAM_ADDR_BITS and PT_RAM_DATA_WIDTH defaults, log2_len width.
- One natural sub-module: pt_drain_buf, the 2-entry skid FIFO plus credit counter for the drain path. The FSM and RAM mux stay in the top module.

Test Plan:
- Reset then start with log2_len=3; stream 8,7,6,5,4,3,2,1; sorter model sorts and pulses done after 50 cycles; out_ready=1 -> out_data 1..8 on 8 consecutive cycles, out_last on value 8, busy low next cycle.
- Same job with out_ready toggling 1,0,0,1 repeating -> no lost or duplicated words; order 1..8 preserved; out_valid never drops while buffer non-empty.
- start with log2_len=11 and ADDR_BITS=10 -> err one cycle, phase stays 0, ram_we never asserted.
- Assert rst during LOAD after 3 beats -> next cycle phase=0, in_ready=0, busy=0; a following job with log2_len=2 completes correctly.
- With PT_SCHED_TIMEOUT_EN and TIMEOUT_CYC=100, sorter never pulses done -> err pulse at SORT cycle 100, phase returns to 0, no out_valid.
- log2_len=0, single input 0xDEADBEEF -> exactly one output beat 0xDEADBEEF with out_last=1.

Source files
------------

// File: rtl/pt_sort_sched_pkg.sv
// ============================================================================
// Module   : pt_sort_sched_pkg
// Purpose  : Shared phase encodings and default sizes for the sort scheduler.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pt_sort_sched_pkg;

  localparam int PT_RAM_ADDR_BITS  = 10;
  localparam int PT_RAM_DATA_WIDTH = 32;
  localparam int PT_LOG2_LEN_W     = 4;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_LOAD  = 2'd1,
    PH_SORT  = 2'd2,
    PH_DRAIN = 2'd3
  } pt_phase_e;

endpackage

`default_nettype wire

// File: rtl/pt_drain_buf.sv
// ============================================================================
// Module   : pt_drain_buf
// Purpose  : 2-entry skid buffer plus read credit logic for the drain stream.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pt_drain_buf
  import pt_sort_sched_pkg::*;
#(
  parameter int DATA_WIDTH = PT_RAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_more,
  input  logic                  rd_last,
  output logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] ram_dob,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  logic [1:0]                 cnt_q, cnt_d, cnt_mid, occ;
  logic [1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]                 last_q, last_d;
  logic                       inflight_q, inflight_d;
  logic                       inflight_last_q, inflight_last_d;
  logic                       pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = data_q[0];
  assign out_last  = out_valid & last_q[0];
  assign pop       = out_valid & out_ready;

  // Credit counts the slot freed by this cycle's pop so a steady stream
  // with out_ready high sustains one read per cycle.
  assign occ      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign rd_issue = rd_more && (occ < 2'd2);

  always_comb begin
    data_d          = data_q;
    last_d          = last_q;
    cnt_mid         = cnt_q;
    inflight_d      = rd_issue;
    inflight_last_d = rd_issue & rd_last;
    if (pop) begin
      data_d[0] = data_q[1];
      last_d[0] = last_q[1];
      cnt_mid   = cnt_q - 2'd1;
    end
    cnt_d = cnt_mid;
    if (inflight_q) begin
      data_d[cnt_mid[0]] = ram_dob;
      last_d[cnt_mid[0]] = inflight_last_q;
      cnt_d              = cnt_mid + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q           <= 2'd0;
      data_q          <= '0;
      last_q          <= 2'b00;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      data_q          <= data_d;
      last_q          <= last_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pt_sort_sched.sv
// ============================================================================
// Module   : pt_sort_sched
// Purpose  : LOAD/SORT/DRAIN job sequencer and point-RAM port owner.
//            Optional SORT watchdog enabled by PT_SCHED_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pt_sort_sched
  import pt_sort_sched_pkg::*;
#(
  parameter int ADDR_BITS   = PT_RAM_ADDR_BITS,
  parameter int DATA_WIDTH  = PT_RAM_DATA_WIDTH,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PT_LOG2_LEN_W-1:0] log2_len,
  output logic                     busy,
  output logic                     err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     sort_start,
  output logic [PT_LOG2_LEN_W-1:0] sort_log2_len,
  input  logic                     sort_done,
  input  logic [ADDR_BITS-1:0]     s_addra,
  input  logic [ADDR_BITS-1:0]     s_addrb,
  input  logic [DATA_WIDTH-1:0]    s_dia,
  input  logic                     s_we,
  output logic [ADDR_BITS-1:0]     ram_addra,
  output logic [ADDR_BITS-1:0]     ram_addrb,
  output logic [DATA_WIDTH-1:0]    ram_dia,
  output logic                     ram_we,
  input  logic [DATA_WIDTH-1:0]    ram_dob,
  output logic [1:0]               phase
);

  // One extra bit lets a full 2^ADDR_BITS job reach its terminal count.
  localparam int CNT_W = ADDR_BITS + 1;

  pt_phase_e                state_q, state_d;
  logic [PT_LOG2_LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic                     err_q, err_d;
  logic                     sort_start_q, sort_start_d;
  logic [CNT_W-1:0]         job_len, last_idx;
  logic                     len_ok;
  logic                     rd_more, rd_last, rd_issue;
  logic                     tmo_hit;

  assign job_len       = {{(CNT_W-1){1'b0}}, 1'b1} << len_q;
  assign last_idx      = job_len - {{(CNT_W-1){1'b0}}, 1'b1};
  assign len_ok        = (int'(log2_len) <= ADDR_BITS);
  assign busy          = (state_q != PH_IDLE);
  assign err           = err_q;
  assign sort_start    = sort_start_q;
  assign sort_log2_len = len_q;
  assign phase         = state_q;

  assign rd_more = (state_q == PH_DRAIN) && (rd_cnt_q < job_len);
  assign rd_last = (rd_cnt_q == last_idx);

`ifdef PT_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == PH_SORT) begin
      tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit = (state_q == PH_SORT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  pt_drain_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_drain_buf (
    .clk       (clk),
    .rst       (rst),
    .rd_more   (rd_more),
    .rd_last   (rd_last),
    .rd_issue  (rd_issue),
    .ram_dob   (ram_dob),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    err_d        = 1'b0;
    sort_start_d = 1'b0;
    in_ready     = 1'b0;
    ram_we       = 1'b0;
    ram_addra    = '0;
    ram_addrb    = '0;
    ram_dia      = '0;

    case (state_q)
      PH_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d    = log2_len;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = PH_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      PH_LOAD: begin
        in_ready  = 1'b1;
        ram_addra = wr_cnt_q[ADDR_BITS-1:0];
        ram_dia   = in_data;
        if (in_valid) begin
          ram_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (wr_cnt_q == last_idx) begin
            state_d      = PH_SORT;
            sort_start_d = 1'b1;
          end
        end
      end

      PH_SORT: begin
        ram_addra = s_addra;
        ram_addrb = s_addrb;
        ram_dia   = s_dia;
        ram_we    = s_we;
        if (sort_done) begin
          state_d  = PH_DRAIN;
          rd_cnt_d = '0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = PH_IDLE;
        end
      end

      PH_DRAIN: begin
        ram_addrb = rd_cnt_q[ADDR_BITS-1:0];
        if (rd_issue) begin
          rd_cnt_d = rd_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (out_valid && out_ready && out_last) begin
          state_d = PH_IDLE;
        end
      end

      default: state_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PH_IDLE;
      len_q        <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      err_q        <= 1'b0;
      sort_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      err_q        <= err_d;
      sort_start_q <= sort_start_d;
    end
  end

endmodule

`default_nettype wire
